// File: rtl/calc_controller.sv
// Sequencer between operand SRAM, the 32-bit adder and the result buffer:
// reads packed operand pairs, steers sums into buffer halves, writes words back.
module calc_controller #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr_i,
  input  logic [ADDR_W-1:0]        read_end_addr_i,
  input  logic [ADDR_W-1:0]        write_start_addr_i,
  output logic                     mem_rd_en_o,
  output logic [ADDR_W-1:0]        mem_rd_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] mem_rd_data_i,
  output logic                     mem_wr_en_o,
  output logic [ADDR_W-1:0]        mem_wr_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wr_data_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  output logic                     loc_sel_o,
  input  logic [MEM_WORD_SIZE-1:0] buffer_i,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ_LO  = 3'd1,
    S_LATCH_LO = 3'd2,
    S_ADD_LO   = 3'd3,
    S_LATCH_HI = 3'd4,
    S_ADD_HI   = 3'd5,
    S_WRITE    = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                rd_req_s;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= {ADDR_W{1'b0}};
      end_q    <= {ADDR_W{1'b0}};
      wr_ptr_q <= {ADDR_W{1'b0}};
      last_q   <= 1'b0;
      op_a_q   <= {DATA_W{1'b0}};
      op_b_q   <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      end_q    <= end_d;
      wr_ptr_q <= wr_ptr_d;
      last_q   <= last_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    end_d    = end_q;
    wr_ptr_d = wr_ptr_q;
    last_d   = last_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_ptr_d = read_start_addr_i;
          end_d    = read_end_addr_i;
          wr_ptr_d = write_start_addr_i;
          last_d   = 1'b0;
          if (read_end_addr_i < read_start_addr_i) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ_LO;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ_LO:  state_d = S_LATCH_LO;
      S_LATCH_LO: begin
        op_a_d   = mem_rd_data_i[DATA_W-1:0];
        op_b_d   = mem_rd_data_i[MEM_WORD_SIZE-1:DATA_W];
        last_d   = (rd_ptr_q == end_q);
        rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        state_d  = S_ADD_LO;
      end
      S_ADD_LO:   state_d = S_LATCH_HI;
      S_LATCH_HI: begin
        // Odd word count: zero operands make the upper half of the final word 0
        if (!last_q) begin
          op_a_d   = mem_rd_data_i[DATA_W-1:0];
          op_b_d   = mem_rd_data_i[MEM_WORD_SIZE-1:DATA_W];
          last_d   = (rd_ptr_q == end_q);
          rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          op_a_d = {DATA_W{1'b0}};
          op_b_d = {DATA_W{1'b0}};
        end
        state_d = S_ADD_HI;
      end
      S_ADD_HI:   state_d = S_WRITE;
      S_WRITE: begin
        wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_READ_LO;
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs decode from flops only; addresses/data are zero when not strobed
  assign rd_req_s      = (state_q == S_READ_LO) || ((state_q == S_ADD_LO) && !last_q);
  assign mem_rd_en_o   = rd_req_s;
  assign mem_rd_addr_o = rd_req_s ? rd_ptr_q : {ADDR_W{1'b0}};
  assign mem_wr_en_o   = (state_q == S_WRITE);
  assign mem_wr_addr_o = mem_wr_en_o ? wr_ptr_q : {ADDR_W{1'b0}};
  assign mem_wr_data_o = mem_wr_en_o ? buffer_i : {MEM_WORD_SIZE{1'b0}};
  assign op_a_o        = op_a_q;
  assign op_b_o        = op_b_q;
  assign loc_sel_o     = (state_q == S_ADD_HI) || (state_q == S_WRITE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller with a behavioural SRAM and result buffer.
module tb_calc_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  read_start_addr_i = 10'd0;
  logic [9:0]  read_end_addr_i = 10'd0;
  logic [9:0]  write_start_addr_i = 10'd0;
  logic        mem_rd_en_o;
  logic [9:0]  mem_rd_addr_o;
  logic [63:0] mem_rd_data_i;
  logic        mem_wr_en_o;
  logic [9:0]  mem_wr_addr_o;
  logic [63:0] mem_wr_data_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        loc_sel_o;
  logic [63:0] buffer_i;
  logic        busy_o;
  logic        done_o;

  logic [63:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [63:0] ld_data = 64'd0;
  logic [63:0] rd_data_r = 64'd0;
  logic [63:0] buf_r = 64'd0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  assign mem_rd_data_i = rd_data_r;
  assign buffer_i      = buf_r;

  calc_controller dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .read_start_addr_i  (read_start_addr_i),
    .read_end_addr_i    (read_end_addr_i),
    .write_start_addr_i (write_start_addr_i),
    .mem_rd_en_o        (mem_rd_en_o),
    .mem_rd_addr_o      (mem_rd_addr_o),
    .mem_rd_data_i      (mem_rd_data_i),
    .mem_wr_en_o        (mem_wr_en_o),
    .mem_wr_addr_o      (mem_wr_addr_o),
    .mem_wr_data_o      (mem_wr_data_o),
    .op_a_o             (op_a_o),
    .op_b_o             (op_b_o),
    .loc_sel_o          (loc_sel_o),
    .buffer_i           (buffer_i),
    .busy_o             (busy_o),
    .done_o             (done_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM, result buffer and traffic counters
  always @(posedge clk_i) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (rst_ni && mem_wr_en_o) mem[mem_wr_addr_o] <= mem_wr_data_o;
    if (mem_rd_en_o) rd_data_r <= mem[mem_rd_addr_o];
    if (loc_sel_o) buf_r[63:32] <= op_a_o + op_b_o;
    else           buf_r[31:0]  <= op_a_o + op_b_o;
    if (rst_ni) begin
      if (mem_wr_en_o) wr_cnt <= wr_cnt + 1;
      if (mem_rd_en_o) rd_cnt <= rd_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [9:0] a, input logic [63:0] d);
    @(negedge clk_i);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk_i);
    ld_en = 1'b0;
  endtask

  // Starts a run from IDLE; lat = negedge index (1 = cycle after the start sample) where done_o seen
  task automatic run(input logic [9:0] rs, input logic [9:0] re, input logic [9:0] ws,
                     input bit poke, output int lat, output int busy_lo);
    lat = 0; busy_lo = 0;
    @(negedge clk_i);
    read_start_addr_i = rs; read_end_addr_i = re; write_start_addr_i = ws;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk_i);
      if (poke && k == 2) begin
        start_i = 1'b1;
        read_start_addr_i = 10'd2; read_end_addr_i = 10'd2; write_start_addr_i = 10'd30;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) lat = k;
      else if (!busy_o) busy_lo++;
    end
  endtask

  initial begin
    int lat, blo, w0, r0, d0;
    // Reset state
    #12;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_strobes", {62'd0, mem_rd_en_o, mem_wr_en_o}, 64'd0);
    check("rst_ops", {op_b_o, op_a_o}, 64'd0);
    check("rst_misc", {43'd0, loc_sel_o, mem_rd_addr_o, mem_wr_addr_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic pair
    load(10'd0, {32'd2, 32'd1});
    load(10'd1, {32'd20, 32'd10});
    load(10'd8, 64'd0);
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    run(10'd0, 10'd1, 10'd8, 1'b0, lat, blo);
    check("basic_lat", 64'(lat), 64'd7);
    check("basic_busy", 64'(blo), 64'd0);
    @(negedge clk_i);
    check("basic_data", mem[8], {32'd30, 32'd3});
    check("basic_writes", 64'(wr_cnt - w0), 64'd1);
    check("basic_reads", 64'(rd_cnt - r0), 64'd2);
    check("basic_done", 64'(done_cnt - d0), 64'd1);

    // Odd count
    load(10'd2, {32'd5, 32'd4});
    load(10'd8, 64'd0);
    load(10'd9, 64'hFFFF_FFFF_FFFF_FFFF);
    w0 = wr_cnt; r0 = rd_cnt;
    run(10'd0, 10'd2, 10'd8, 1'b0, lat, blo);
    check("odd_lat", 64'(lat), 64'd13);
    @(negedge clk_i);
    check("odd_w0", mem[8], {32'd30, 32'd3});
    check("odd_w1", mem[9], {32'd0, 32'd9});
    check("odd_writes", 64'(wr_cnt - w0), 64'd2);
    check("odd_reads", 64'(rd_cnt - r0), 64'd3);

    // Overflow wrap
    load(10'd0, {32'h1, 32'hFFFF_FFFF});
    load(10'd1, {32'h1, 32'h1});
    run(10'd0, 10'd1, 10'd16, 1'b0, lat, blo);
    @(negedge clk_i);
    check("ovf_data", mem[16], {32'h2, 32'h0});

    // Zero-length run
    w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
    run(10'd5, 10'd4, 10'd8, 1'b0, lat, blo);
    check("zero_lat", 64'(lat), 64'd1);
    @(negedge clk_i);
    check("zero_reads", 64'(rd_cnt - r0), 64'd0);
    check("zero_writes", 64'(wr_cnt - w0), 64'd0);
    check("zero_done", 64'(done_cnt - d0), 64'd1);

    // Mid-run reset in ADD_HI
    load(10'd0, {32'd2, 32'd1});
    load(10'd1, {32'd20, 32'd10});
    load(10'd20, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk_i);
    read_start_addr_i = 10'd0; read_end_addr_i = 10'd1; write_start_addr_i = 10'd20;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check("mid_in_addhi", {63'd0, loc_sel_o}, 64'd1);
    w0 = wr_cnt; d0 = done_cnt;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_busy", {63'd0, busy_o}, 64'd0);
    check("mid_outs", {60'd0, loc_sel_o, done_o, mem_rd_en_o, mem_wr_en_o}, 64'd0);
    check("mid_ops", {op_b_o, op_a_o}, 64'd0);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check("mid_no_write", 64'(wr_cnt - w0), 64'd0);
    check("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("mid_mem", mem[20], 64'hDEAD_BEEF_0000_0001);
    run(10'd0, 10'd1, 10'd21, 1'b0, lat, blo);
    @(negedge clk_i);
    check("mid_rerun_lat", 64'(lat), 64'd7);
    check("mid_rerun_data", mem[21], {32'd30, 32'd3});

    // Start while busy
    load(10'd24, 64'd0);
    load(10'd30, 64'd0);
    w0 = wr_cnt; d0 = done_cnt;
    run(10'd0, 10'd1, 10'd24, 1'b1, lat, blo);
    check("busy_lat", 64'(lat), 64'd7);
    repeat (10) @(negedge clk_i);
    check("busy_data", mem[24], {32'd30, 32'd3});
    check("busy_other", mem[30], 64'd0);
    check("busy_writes", 64'(wr_cnt - w0), 64'd1);
    check("busy_done", 64'(done_cnt - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
- Sequencing FSM that sits directly upstream of the result buffer.
- Reads packed operand words from SRAM and drives operands to the 32-bit adder.
- Steers each adder result into the lower or upper half of the result buffer via loc_sel_o.
- Writes each completed 64-bit buffer word back to SRAM; one run processes an address range and flags completion.

Parameters:
DATA_W, 32, adder operand/result width (from calculator_pkg)
MEM_WORD_SIZE, 64, SRAM word width; equals 2*DATA_W
ADDR_W, 10, SRAM address width

Ports:
clk_i  in  1  clock, all state on posedge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin a run; sampled in IDLE only
read_start_addr_i  in  ADDR_W  first operand word address
read_end_addr_i  in  ADDR_W  last operand word address (inclusive)
write_start_addr_i  in  ADDR_W  first result word address
mem_rd_en_o  out  1  SRAM read strobe
mem_rd_addr_o  out  ADDR_W  SRAM read address
mem_rd_data_i  in  MEM_WORD_SIZE  SRAM read data, valid one cycle after mem_rd_en_o
mem_wr_en_o  out  1  SRAM write strobe
mem_wr_addr_o  out  ADDR_W  SRAM write address
mem_wr_data_o  out  MEM_WORD_SIZE  SRAM write data
op_a_o  out  DATA_W  adder operand A, registered
op_b_o  out  DATA_W  adder operand B, registered
loc_sel_o  out  1  result buffer half select: 0 = lower, 1 = upper
buffer_i  in  MEM_WORD_SIZE  result buffer contents
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (rst_ni low, asynchronous):
  - State returns to IDLE.
  - All outputs and internal pointers/registers clear to 0.
  - A reset during a run aborts it immediately: no further reads or writes, and no done_o pulse.
- Operand packing: op_a = word[DATA_W-1:0], op_b = word[MEM_WORD_SIZE-1:DATA_W]. Adder overflow wraps; this block ignores carry.
- Result buffer interaction: the result buffer captures every cycle into the half given by loc_sel_o. This block therefore holds op_a_o, op_b_o and loc_sel_o stable until the intended capture edge has passed.
- States:
  - IDLE: on start_i=1, latch rd_ptr=read_start_addr_i, end=read_end_addr_i, wr_ptr=write_start_addr_i.
    - If read_end_addr_i < read_start_addr_i, go to DONE (zero-length run, no memory traffic).
    - Otherwise go to READ_LO.
  - READ_LO: mem_rd_en_o=1, mem_rd_addr_o=rd_ptr. Go to LATCH_LO.
  - LATCH_LO: register op_a/op_b from mem_rd_data_i; loc_sel_o=0.
    - Set flag last = (rd_ptr==end); rd_ptr++.
    - Go to ADD_LO.
  - ADD_LO: loc_sel_o=0; the buffer captures the lower half at the end of this cycle.
    - If !last: mem_rd_en_o=1, mem_rd_addr_o=rd_ptr.
    - Go to LATCH_HI.
  - LATCH_HI: loc_sel_o=0.
    - If !last: register operands from mem_rd_data_i, set last=(rd_ptr==end), rd_ptr++.
    - If last was already set: op_a=op_b=0, so an odd word count yields an upper half of 0.
    - Go to ADD_HI.
  - ADD_HI: loc_sel_o=1; the buffer captures the upper half at the end of this cycle. Go to WRITE.
  - WRITE: mem_wr_en_o=1, mem_wr_addr_o=wr_ptr, mem_wr_data_o=buffer_i; loc_sel_o=1; wr_ptr++.
    - Go to DONE if last, else READ_LO.
  - DONE: done_o=1 for exactly one cycle. Go to IDLE.
- Start handling: start_i is ignored in every state except IDLE. Holding start_i high starts a new run on the cycle after DONE.
- Throughput: 6 cycles per output word. A range of N words produces ceil(N/2) writes at consecutive addresses from write_start_addr_i.
- Address wrap: rd_ptr and wr_ptr wrap modulo 2^ADDR_W. end == 2^ADDR_W-1 terminates correctly because termination uses the last flag, not rd_ptr > end.
- Idle outputs: mem_rd_en_o and mem_wr_en_o are low in every state not listed above as asserting them.

Test Plan:
- Basic pair:
  - Stimulus: mem[0]={32'd2,32'd1}, mem[1]={32'd20,32'd10}; start with rd 0..1, wr 8.
  - Response: exactly one write, mem[8]={32'd30,32'd3}; done_o pulses 7 cycles after the start_i sample; busy_o high throughout.
- Odd count:
  - Stimulus: range 0..2 with mem[2]={32'd5,32'd4}; wr 8.
  - Response: mem[8]=as above; mem[9]={32'd0,32'd9}; two writes total.
- Overflow wrap:
  - Stimulus: mem[0]={32'h1,32'hFFFFFFFF}, mem[1]={32'h1,32'h1}.
  - Response: written word {32'h2,32'h0}.
- Zero-length run:
  - Stimulus: start with rd 5..4.
  - Response: no mem_rd_en_o or mem_wr_en_o; done_o pulses on the cycle after the start_i sample.
- Mid-run reset:
  - Stimulus: drop rst_ni asynchronously (between clock edges) while in ADD_HI.
  - Response: all outputs 0 immediately; no write issued; no done_o pulse; after release, start_i from IDLE runs cleanly.
- Start while busy:
  - Stimulus: pulse start_i during LATCH_LO with different addresses.
  - Response: pulse ignored; original run completes unchanged with a single done_o.
